// File: rtl/pwm_mode_ctrl_if.sv
// Signal bundle between the push-button/auto-rotate mode controller and its environment.
// The slave side is the controller itself; the master side supplies key and auto-enable.
interface pwm_mode_ctrl_if;
  logic       key_in;
  logic       auto_en;
  logic [1:0] mode;
  logic       mode_chg;
  logic       key_pressed;

  modport master (
    output key_in,
    output auto_en,
    input  mode,
    input  mode_chg,
    input  key_pressed
  );

  modport slave (
    input  key_in,
    input  auto_en,
    output mode,
    output mode_chg,
    output key_pressed
  );
endinterface

// File: rtl/pwm_mode_ctrl.sv
// Mode select generator for Driver_PWM: synchronises and debounces a push-button and
// steps a wrapping mode counter on each press and/or on a periodic auto-rotate timer.
module pwm_mode_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         AUTO_PERIOD     = 50000000,
  parameter int         NUM_MODES       = 3,
  parameter logic [1:0] RESET_MODE      = 2'b10,
  parameter int         KEY_ACTIVE_LOW  = 1
) (
  input logic            ext_clk_25m,
  input logic            ext_rst,
  pwm_mode_ctrl_if.slave bus
);

  localparam int         DW           = $clog2(DEBOUNCE_CYCLES);
  localparam int         AW           = $clog2(AUTO_PERIOD);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [1:0] LAST_MODE    = 2'(NUM_MODES - 1);
  localparam logic       KEY_RELEASED = (KEY_ACTIVE_LOW != 0);
  localparam logic       CAN_ADVANCE  = (NUM_MODES > 1);

  logic [1:0]    rst_pipe;
  logic          rst;
  logic          key_meta;
  logic          key_sync;
  logic          key_level;
  logic [DW-1:0] db_cnt;
  logic          key_pressed;
  logic          key_pressed_d;
  logic [AW-1:0] auto_cnt;
  logic [1:0]    mode;
  logic          mode_chg;
  logic          press_evt;
  logic          auto_evt;
  logic          advance;
  logic [1:0]    next_mode;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
    if (ext_rst) rst_pipe <= 2'b11;
    else         rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst = rst_pipe[1];

  always_ff @(posedge ext_clk_25m or posedge rst) begin
    if (rst) begin
      key_meta <= KEY_RELEASED;
      key_sync <= KEY_RELEASED;
    end else begin
      key_meta <= bus.key_in;
      key_sync <= key_meta;
    end
  end

  assign key_level = key_sync ^ KEY_RELEASED;

  // A new level is accepted only after it has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge ext_clk_25m or posedge rst) begin
    if (rst) begin
      db_cnt        <= '0;
      key_pressed   <= 1'b0;
      key_pressed_d <= 1'b0;
    end else begin
      key_pressed_d <= key_pressed;
      if (key_level == key_pressed) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt      <= '0;
        key_pressed <= key_level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    press_evt = key_pressed & ~key_pressed_d;
    auto_evt  = bus.auto_en && (auto_cnt == AUTO_LAST);
    advance   = CAN_ADVANCE && (press_evt || auto_evt);
    next_mode = (mode == LAST_MODE) ? 2'd0 : mode + 2'd1;
  end

  // Any advance restarts the period so auto steps are spaced from the latest change.
  always_ff @(posedge ext_clk_25m or posedge rst) begin
    if (rst) begin
      auto_cnt <= '0;
      mode     <= RESET_MODE;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= advance;
      if (advance) begin
        mode     <= next_mode;
        auto_cnt <= '0;
      end else if (bus.auto_en) begin
        auto_cnt <= auto_cnt + 1'b1;
      end else begin
        auto_cnt <= '0;
      end
    end
  end

  assign bus.mode        = mode;
  assign bus.mode_chg    = mode_chg;
  assign bus.key_pressed = key_pressed;

endmodule

// File: tb/tb_pwm_mode_ctrl.sv
// Scoreboard bench for pwm_mode_ctrl: stimulus queues the expected mode and change cycle,
// a negedge monitor pops one entry per mode_chg pulse and compares value and timing.
module tb_pwm_mode_ctrl;

  typedef struct {
    logic [1:0] mode;
    int         cycle;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic       bounce_seen;
  logic [1:0] wrap_seq[4];
  int         start_cyc;

  pwm_mode_ctrl_if bus ();

  pwm_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (20),
    .NUM_MODES      (3),
    .RESET_MODE     (2'b10),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .ext_clk_25m(clk),
    .ext_rst    (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Every mode_chg pulse must match the oldest queued expectation in both value and cycle.
  always @(negedge clk) begin
    if (bus.mode_chg === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_mode_chg: got mode=%0d at cycle %0d, required no change",
                 bus.mode, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.mode !== mon_e.mode || cyc != mon_e.cycle) begin
          n_fail++;
          $display("[TB] FAIL mode_step: got mode=%0d at cycle %0d, required mode=%0d at cycle %0d",
                   bus.mode, cyc, mon_e.mode, mon_e.cycle);
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic expect_change(input logic [1:0] m, input int c);
    sb.push_back('{mode: m, cycle: c});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a key level for n cycles while recording whether the debounced level ever rose.
  task automatic apply_stimulus(input logic level, input int n);
    bus.key_in = level;
    repeat (n) begin
      @(negedge clk);
      if (bus.key_pressed === 1'b1) bounce_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.key_in  = 1'b1;
    bus.auto_en = 1'b0;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(5);
  endtask

  initial begin
    bus.key_in  = 1'b1;
    bus.auto_en = 1'b0;
    wrap_seq[0] = 2'd0;
    wrap_seq[1] = 2'd1;
    wrap_seq[2] = 2'd2;
    wrap_seq[3] = 2'd0;

    // Reset state, both while held and after release
    wait_cycles(5);
    check_output("rst_mode", int'(bus.mode), 2);
    check_output("rst_mode_chg", int'(bus.mode_chg), 0);
    check_output("rst_key_pressed", int'(bus.key_pressed), 0);
    rst = 1'b0;
    wait_cycles(5);
    check_output("post_rst_mode", int'(bus.mode), 2);
    check_output("post_rst_key_pressed", int'(bus.key_pressed), 0);

    // Clean press: debounced level at +6, mode step at +7
    start_cyc = cyc;
    expect_change(2'd0, start_cyc + 7);
    bus.key_in = 1'b0;
    wait_cycles(5);
    check_output("press_kp_early", int'(bus.key_pressed), 0);
    wait_cycles(1);
    check_output("press_kp_rise", int'(bus.key_pressed), 1);
    wait_cycles(4);
    bus.key_in = 1'b1;
    wait_cycles(12);
    check_output("release_kp", int'(bus.key_pressed), 0);
    check_output("press_mode", int'(bus.mode), 0);

    // Bouncing key never accepted, then a steady press gives one step
    bounce_seen = 1'b0;
    apply_stimulus(1'b0, 3);
    apply_stimulus(1'b1, 1);
    apply_stimulus(1'b0, 2);
    apply_stimulus(1'b1, 10);
    check_output("bounce_kp", int'(bounce_seen), 0);
    check_output("bounce_mode", int'(bus.mode), 0);
    start_cyc = cyc;
    expect_change(2'd1, start_cyc + 7);
    apply_stimulus(1'b0, 8);
    apply_stimulus(1'b1, 12);
    check_output("bounce_then_press_mode", int'(bus.mode), 1);

    // Wrap sequence from reset mode
    do_reset();
    check_output("wrap_start_mode", int'(bus.mode), 2);
    for (int i = 0; i < 4; i++) begin
      start_cyc = cyc;
      expect_change(wrap_seq[i], start_cyc + 7);
      apply_stimulus(1'b0, 8);
      apply_stimulus(1'b1, 12);
    end
    check_output("wrap_end_mode", int'(bus.mode), 0);

    // Auto rotate: steps at +20 and +40, disabled at +50 so nothing at +60
    do_reset();
    start_cyc = cyc;
    expect_change(2'd0, start_cyc + 20);
    expect_change(2'd1, start_cyc + 40);
    bus.auto_en = 1'b1;
    wait_cycles(50);
    bus.auto_en = 1'b0;
    wait_cycles(15);
    check_output("auto_mode", int'(bus.mode), 1);
    check_output("auto_pending", sb.size(), 0);

    // Press event landing on the auto event gives one step, next auto a full period later
    start_cyc = cyc;
    expect_change(2'd2, start_cyc + 20);
    expect_change(2'd0, start_cyc + 40);
    bus.auto_en = 1'b1;
    wait_cycles(13);
    bus.key_in = 1'b0;
    wait_cycles(10);
    bus.key_in = 1'b1;
    wait_cycles(19);
    bus.auto_en = 1'b0;
    wait_cycles(10);
    check_output("collision_mode", int'(bus.mode), 0);

    // Reset mid-debounce: immediate reset mode, no pulse on exit
    bus.key_in = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    #1;
    check_output("rst_async_mode", int'(bus.mode), 2);
    check_output("rst_async_mode_chg", int'(bus.mode_chg), 0);
    bus.key_in = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(20);
    check_output("rst_exit_mode", int'(bus.mode), 2);
    check_output("rst_exit_kp", int'(bus.key_pressed), 0);

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      n_fail++;
      $display("[TB] FAIL missing_mode_chg: got no pulse, required mode=%0d at cycle %0d",
               mon_e.mode, mon_e.cycle);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
